// File: rtl/c_sel_merge2_d.sv
// Purpose: clocked 2-to-1 conditional merge; forwards one pending branch downstream with a one-hot source tag and routes the downstream free back to it.
// Latency: drive sampled at edge E -> o_driveNext during the cycle after E+1; free sampled at F -> o_freeW during the cycle after F.
// Backpressure: one token in flight (single downstream credit); a re-drive on a still-pending branch is dropped and flagged on the sticky o_err.
// Build option: define CSELMERGE_RR_EN for round-robin arbitration; the default build uses fixed priority (branch 0 wins).
module c_sel_merge2_d #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic                  i_drive1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_free0,
  output logic                  o_free1,
  output logic                  o_driveNext,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid0,
  output logic                  o_valid1,
  input  logic                  i_freeNext,
  output logic                  o_err
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_WAIT = 1'b1;

  logic                  state;
  logic                  credit;
  logic                  servedSel;
  logic                  pend0;
  logic                  pend1;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  winSel;
  logic                  launch;
  logic                  freeHit;
  logic                  clear0;
  logic                  clear1;

  // Transfer start and free routing decoded from the current state.
  always_comb begin
    launch  = (state == STATE_IDLE) && credit && (pend0 || pend1);
    freeHit = (state == STATE_WAIT) && i_freeNext;
    clear0  = freeHit && !servedSel;
    clear1  = freeHit && servedSel;
  end

`ifdef CSELMERGE_RR_EN
  logic lastPtr;

  // Round-robin: on a tie serve the branch that was not served last.
  always_comb begin
    winSel = 1'b0;
    if (pend0 && pend1) winSel = ~lastPtr;
    else                winSel = !pend0;
  end

  // Remember the last served branch; reset value 1 makes branch 0 win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lastPtr <= 1'b1;
    else if (launch) lastPtr <= winSel;
  end
`else
  // Fixed priority: branch 0 wins whenever it is pending.
  always_comb begin
    winSel = !pend0;
  end
`endif

  // Capture branch tokens; a drive on a pending branch (even on its clearing edge) is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      if (clear0) begin
        pend0 <= 1'b0;
      end else if (i_drive0 && !pend0) begin
        pend0 <= 1'b1;
        buf0  <= i_data0;
      end
      if (clear1) begin
        pend1 <= 1'b0;
      end else if (i_drive1 && !pend1) begin
        pend1 <= 1'b1;
        buf1  <= i_data1;
      end
    end
  end

  // Sticky protocol error: overlapping drives or a free with nothing in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err <= 1'b0;
    end else if ((i_drive0 && pend0) || (i_drive1 && pend1) ||
                 (i_freeNext && state != STATE_WAIT)) begin
      o_err <= 1'b1;
    end
  end

  // Transfer FSM: launch the winner downstream, then wait for its free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= STATE_IDLE;
      credit      <= 1'b1;
      servedSel   <= 1'b0;
      o_driveNext <= 1'b0;
      o_free0     <= 1'b0;
      o_free1     <= 1'b0;
      o_data      <= '0;
      o_valid0    <= 1'b0;
      o_valid1    <= 1'b0;
    end else begin
      o_driveNext <= 1'b0;
      o_free0     <= 1'b0;
      o_free1     <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (launch) begin
            o_data      <= winSel ? buf1 : buf0;
            o_valid0    <= !winSel;
            o_valid1    <= winSel;
            o_driveNext <= 1'b1;
            servedSel   <= winSel;
            credit      <= 1'b0;
            state       <= STATE_WAIT;
          end
        end
        default: begin
          if (freeHit) begin
            o_free0 <= !servedSel;
            o_free1 <= servedSel;
            credit  <= 1'b1;
            state   <= STATE_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c_sel_merge2_d.sv
// Directed bench for c_sel_merge2_d with a scoreboard of expected forwarded tokens.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Arbitration expectations follow CSELMERGE_RR_EN when it is defined.
module tb_c_sel_merge2_d;

  logic        clk;
  logic        rst;
  logic        i_drive0;
  logic [31:0] i_data0;
  logic        i_drive1;
  logic [31:0] i_data1;
  logic        o_free0;
  logic        o_free1;
  logic        o_driveNext;
  logic [31:0] o_data;
  logic        o_valid0;
  logic        o_valid1;
  logic        i_freeNext;
  logic        o_err;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  c_sel_merge2_d #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_drive0   (i_drive0),
    .i_data0    (i_data0),
    .i_drive1   (i_drive1),
    .i_data1    (i_data1),
    .o_free0    (o_free0),
    .o_free1    (o_free1),
    .o_driveNext(o_driveNext),
    .o_data     (o_data),
    .o_valid0   (o_valid0),
    .o_valid1   (o_valid1),
    .i_freeNext (i_freeNext),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic d0, input logic [31:0] v0,
                     input logic d1, input logic [31:0] v1);
    i_drive0 = d0;
    i_data0  = v0;
    i_drive1 = d1;
    i_data1  = v1;
    tick();
    i_drive0 = 1'b0;
    i_drive1 = 1'b0;
  endtask

  // Waits (bounded) for o_driveNext, compares against the scoreboard head,
  // then checks the pulse is one cycle wide with data/tags held.
  task automatic waitDrive(input string tag, output int cycles);
    exp_t e;
    cycles = 0;
    while (o_driveNext !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    chk({tag, "_drive"}, 32'(o_driveNext), 32'd1);
    chk({tag, "_sb_has_entry"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_data"}, o_data, e.data);
      chk({tag, "_valid0"}, 32'(o_valid0), 32'(!e.src));
      chk({tag, "_valid1"}, 32'(o_valid1), 32'(e.src));
      tick();
      chk({tag, "_pulse_end"}, 32'(o_driveNext), 32'd0);
      chk({tag, "_data_held"}, o_data, e.data);
    end
  endtask

  task automatic doFree(input string tag, input logic exp0, input logic exp1);
    i_freeNext = 1'b1;
    tick();
    i_freeNext = 1'b0;
    chk({tag, "_free0"}, 32'(o_free0), 32'(exp0));
    chk({tag, "_free1"}, 32'(o_free1), 32'(exp1));
  endtask

  initial begin
    int   cyc;
    logic firstSrc;

    rst        = 1'b1;
    i_drive0   = 1'b0;
    i_data0    = '0;
    i_drive1   = 1'b0;
    i_data1    = '0;
    i_freeNext = 1'b0;
    tick();
    tick();
    chk("rst_driveNext", 32'(o_driveNext), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_valid", {30'd0, o_valid1, o_valid0}, 32'd0);
    chk("rst_free", {30'd0, o_free1, o_free0}, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    rst = 1'b0;
    tick();

    // T1: single token on branch 0
    sbq.push_back('{src: 1'b0, data: 32'hA5A5_0001});
    drv(1'b1, 32'hA5A5_0001, 1'b0, 32'h0);
    chk("t1_not_early", 32'(o_driveNext), 32'd0);
    waitDrive("t1", cyc);
    chk("t1_latency", 32'(cyc), 32'd1);
    tick();
    doFree("t1", 1'b1, 1'b0);
    tick();
    chk("t1_free_pulse_end", {30'd0, o_free1, o_free0}, 32'd0);

    // T2: both branches on the same edge
    sbq.push_back('{src: 1'b0, data: 32'd1});
    sbq.push_back('{src: 1'b1, data: 32'd2});
    drv(1'b1, 32'd1, 1'b1, 32'd2);
    waitDrive("t2a", cyc);
    doFree("t2a", 1'b1, 1'b0);
    waitDrive("t2b", cyc);
    chk("t2b_back_to_back", 32'(cyc), 32'd1);
    doFree("t2b", 1'b0, 1'b1);

    // T3: branch 0 served last, then a tie decides the arbitration policy
    sbq.push_back('{src: 1'b0, data: 32'd10});
    drv(1'b1, 32'd10, 1'b0, 32'h0);
    waitDrive("t3a", cyc);
    doFree("t3a", 1'b1, 1'b0);
`ifdef CSELMERGE_RR_EN
    firstSrc = 1'b1;
    sbq.push_back('{src: 1'b1, data: 32'd12});
    sbq.push_back('{src: 1'b0, data: 32'd11});
`else
    firstSrc = 1'b0;
    sbq.push_back('{src: 1'b0, data: 32'd11});
    sbq.push_back('{src: 1'b1, data: 32'd12});
`endif
    drv(1'b1, 32'd11, 1'b1, 32'd12);
    waitDrive("t3b", cyc);
    doFree("t3b", !firstSrc, firstSrc);
    waitDrive("t3c", cyc);
    doFree("t3c", firstSrc, !firstSrc);
    chk("t3_no_err", 32'(o_err), 32'd0);

    // T4: protocol violations
    sbq.push_back('{src: 1'b0, data: 32'hBEEF_0004});
    drv(1'b1, 32'hBEEF_0004, 1'b0, 32'h0);
    waitDrive("t4", cyc);
    drv(1'b1, 32'hDEAD_0000, 1'b0, 32'h0);
    chk("t4_err_set", 32'(o_err), 32'd1);
    chk("t4_data_unchanged", o_data, 32'hBEEF_0004);
    doFree("t4", 1'b1, 1'b0);
    tick();
    tick();
    chk("t4_dropped_drive", 32'(o_driveNext), 32'd0);
    doFree("t4_stray", 1'b0, 1'b0);
    tick();
    chk("t4_err_sticky", 32'(o_err), 32'd1);
    chk("t4_stray_no_drive", 32'(o_driveNext), 32'd0);

    // T5: reset in the middle of a transfer
    sbq.push_back('{src: 1'b0, data: 32'h55});
    drv(1'b1, 32'h55, 1'b0, 32'h0);
    waitDrive("t5a", cyc);
    rst = 1'b1;
    #1;
    chk("t5_rst_data", o_data, 32'd0);
    chk("t5_rst_valid", {30'd0, o_valid1, o_valid0}, 32'd0);
    chk("t5_rst_err", 32'(o_err), 32'd0);
    chk("t5_rst_free", {30'd0, o_free1, o_free0}, 32'd0);
    tick();
    rst = 1'b0;
    sbq.push_back('{src: 1'b1, data: 32'd7});
    drv(1'b0, 32'h0, 1'b1, 32'd7);
    waitDrive("t5b", cyc);
    chk("t5b_latency", 32'(cyc), 32'd1);
    doFree("t5b", 1'b0, 1'b1);
    chk("t5_err_clear", 32'(o_err), 32'd0);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
